l1_metadata_array_param: RTL and testbench

L1_METADATA_ARRAY_PARAM -- requirements
Module: l1_metadata_array_param

---
 rtl/l1_metadata_array_param.sv | 177 +++++++++++++++++
 tb/tb_l1_metadata_array_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_metadata_array_param.sv
// ---------------------------------------------------------------------------
// l1_metadata_array_param
//
// Purpose: per-set, per-way metadata store (coherence state + tag) for an L1
// cache. The store comes out of reset by sweeping every set to the invalid
// state. After the sweep it accepts writes, flushes and tag lookups. A flush
// starts the same invalidation sweep again.
//
// Ports:
//   clock, reset            rising-edge clock; synchronous active-high reset
//   io_read_*               lookup request (set index + tag), valid/ready
//   io_write_*              masked write of {coh, tag} into the enabled ways
//   io_flush_valid/ready    request to invalidate the whole array
//   io_resp_valid           one-cycle strobe, one cycle after a read fires
//   io_resp_coh/tag         per-way metadata; way w at [w*W +: W], held
//   io_resp_hit/hit_way     lowest matching valid way (one-hot), held
//   io_busy                 high while the invalidation sweep runs
//
// Priority when several requests are valid: write > flush > read.
// ---------------------------------------------------------------------------
module l1_metadata_array_param #(
  parameter  int NSETS = 64,
  parameter  int NWAYS = 8,
  parameter  int TAG_W = 21,
  parameter  int COH_W = 2,
  localparam int IDX_W = $clog2(NSETS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_read_valid,
  output logic                     io_read_ready,
  input  logic [IDX_W-1:0]         io_read_bits_idx,
  input  logic [TAG_W-1:0]         io_read_bits_tag,
  input  logic                     io_write_valid,
  output logic                     io_write_ready,
  input  logic [IDX_W-1:0]         io_write_bits_idx,
  input  logic [NWAYS-1:0]         io_write_bits_way_en,
  input  logic [COH_W-1:0]         io_write_bits_coh,
  input  logic [TAG_W-1:0]         io_write_bits_tag,
  input  logic                     io_flush_valid,
  output logic                     io_flush_ready,
  output logic                     io_resp_valid,
  output logic [NWAYS*COH_W-1:0]   io_resp_coh,
  output logic [NWAYS*TAG_W-1:0]   io_resp_tag,
  output logic                     io_resp_hit,
  output logic [NWAYS-1:0]         io_resp_hit_way,
  output logic                     io_busy
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic [COH_W-1:0] coh_mem [NSETS][NWAYS];
  logic [TAG_W-1:0] tag_mem [NSETS][NWAYS];

  logic read_fire, write_fire, flush_fire;

  logic [NWAYS*COH_W-1:0] rd_coh_p0;
  logic [NWAYS*TAG_W-1:0] rd_tag_p0;
  logic [NWAYS-1:0]       match_p0;
  logic [NWAYS-1:0]       hit_way_p0;

  logic                   vld_p1;
  logic [NWAYS*COH_W-1:0] coh_p1;
  logic [NWAYS*TAG_W-1:0] tag_p1;
  logic [NWAYS-1:0]       hit_way_p1;

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [NWAYS-1:0] lowest_one(input logic [NWAYS-1:0] v);
    return v & (~v + 1'b1);
  endfunction

  assign io_busy        = (state_q == CLEAR);
  assign io_write_ready = (state_q == READY);
  assign io_flush_ready = (state_q == READY) && !io_write_valid;
  assign io_read_ready  = (state_q == READY) && !io_write_valid && !io_flush_valid;

  assign write_fire = io_write_valid && io_write_ready;
  assign flush_fire = io_flush_valid && io_flush_ready;
  assign read_fire  = io_read_valid  && io_read_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Flush requests seen while already sweeping are dropped on purpose: the
  // sweep is already invalidating everything, so restarting gains nothing.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      CLEAR: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == IDX_W'(NSETS - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (flush_fire) begin
          state_d = CLEAR;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        sweep_d = '0;
      end
    endcase
  end

  // Storage carries no reset; the sweep is what establishes its contents.
  always_ff @(posedge clock) begin
    if (state_q == CLEAR) begin
      for (int w = 0; w < NWAYS; w++) begin
        coh_mem[sweep_q][w] <= '0;
        tag_mem[sweep_q][w] <= '0;
      end
    end else if (write_fire) begin
      for (int w = 0; w < NWAYS; w++) begin
        if (io_write_bits_way_en[w]) begin
          coh_mem[io_write_bits_idx][w] <= io_write_bits_coh;
          tag_mem[io_write_bits_idx][w] <= io_write_bits_tag;
        end
      end
    end
  end

  // ---- stage p0: array read and tag compare in the read-fire cycle ----
  // A read can only fire when no write fires, so the array read here equals
  // the contents at the end of this cycle. Comparing now against the request
  // tag is equivalent to comparing the captured data against a registered tag.
  always_comb begin
    rd_coh_p0 = '0;
    rd_tag_p0 = '0;
    match_p0  = '0;
    for (int w = 0; w < NWAYS; w++) begin
      rd_coh_p0[w*COH_W +: COH_W] = coh_mem[io_read_bits_idx][w];
      rd_tag_p0[w*TAG_W +: TAG_W] = tag_mem[io_read_bits_idx][w];
      match_p0[w] = (coh_mem[io_read_bits_idx][w] != '0) &&
                    (tag_mem[io_read_bits_idx][w] == io_read_bits_tag);
    end
  end

  assign hit_way_p0 = lowest_one(match_p0);

  // ---- stage p1: registered response, held until the next read fires ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      coh_p1     <= '0;
      tag_p1     <= '0;
      hit_way_p1 <= '0;
    end else begin
      vld_p1 <= read_fire;
      if (read_fire) begin
        coh_p1     <= rd_coh_p0;
        tag_p1     <= rd_tag_p0;
        hit_way_p1 <= hit_way_p0;
      end
    end
  end

  assign io_resp_valid   = vld_p1;
  assign io_resp_coh     = coh_p1;
  assign io_resp_tag     = tag_p1;
  assign io_resp_hit_way = hit_way_p1;
  assign io_resp_hit     = |hit_way_p1;

endmodule

// File: tb/tb_l1_metadata_array_param.sv
// ---------------------------------------------------------------------------
// tb_l1_metadata_array_param
//
// Directed, table-driven bench for l1_metadata_array_param: a default
// instance (64 sets x 8 ways) plus a 16 x 4 instance with odd widths.
// ---------------------------------------------------------------------------
module tb_l1_metadata_array_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;

  // ---------------- default instance ----------------
  logic         reset = 1'b1;
  logic         io_read_valid = 0, io_read_ready;
  logic [5:0]   io_read_bits_idx = 0;
  logic [20:0]  io_read_bits_tag = 0;
  logic         io_write_valid = 0, io_write_ready;
  logic [5:0]   io_write_bits_idx = 0;
  logic [7:0]   io_write_bits_way_en = 0;
  logic [1:0]   io_write_bits_coh = 0;
  logic [20:0]  io_write_bits_tag = 0;
  logic         io_flush_valid = 0, io_flush_ready;
  logic         io_resp_valid, io_resp_hit, io_busy;
  logic [15:0]  io_resp_coh;
  logic [167:0] io_resp_tag;
  logic [7:0]   io_resp_hit_way;

  l1_metadata_array_param dut (
    .clock(clock), .reset(reset),
    .io_read_valid(io_read_valid), .io_read_ready(io_read_ready),
    .io_read_bits_idx(io_read_bits_idx), .io_read_bits_tag(io_read_bits_tag),
    .io_write_valid(io_write_valid), .io_write_ready(io_write_ready),
    .io_write_bits_idx(io_write_bits_idx), .io_write_bits_way_en(io_write_bits_way_en),
    .io_write_bits_coh(io_write_bits_coh), .io_write_bits_tag(io_write_bits_tag),
    .io_flush_valid(io_flush_valid), .io_flush_ready(io_flush_ready),
    .io_resp_valid(io_resp_valid), .io_resp_coh(io_resp_coh), .io_resp_tag(io_resp_tag),
    .io_resp_hit(io_resp_hit), .io_resp_hit_way(io_resp_hit_way), .io_busy(io_busy)
  );

  // ---------------- small instance ----------------
  logic        reset2 = 1'b1;
  logic        rv2 = 0, rr2;
  logic [3:0]  ridx2 = 0;
  logic [11:0] rtag2 = 0;
  logic        wv2 = 0, wr2;
  logic [3:0]  widx2 = 0;
  logic [3:0]  wen2 = 0;
  logic [2:0]  wcoh2 = 0;
  logic [11:0] wtag2 = 0;
  logic        fv2 = 0, fr2;
  logic        respv2, hit2, busy2;
  logic [11:0] rcoh2;
  logic [47:0] rtago2;
  logic [3:0]  hw2;

  l1_metadata_array_param #(.NSETS(16), .NWAYS(4), .TAG_W(12), .COH_W(3)) dut2 (
    .clock(clock), .reset(reset2),
    .io_read_valid(rv2), .io_read_ready(rr2),
    .io_read_bits_idx(ridx2), .io_read_bits_tag(rtag2),
    .io_write_valid(wv2), .io_write_ready(wr2),
    .io_write_bits_idx(widx2), .io_write_bits_way_en(wen2),
    .io_write_bits_coh(wcoh2), .io_write_bits_tag(wtag2),
    .io_flush_valid(fv2), .io_flush_ready(fr2),
    .io_resp_valid(respv2), .io_resp_coh(rcoh2), .io_resp_tag(rtago2),
    .io_resp_hit(hit2), .io_resp_hit_way(hw2), .io_busy(busy2)
  );

  typedef struct {
    logic         wv, fv, rv;
    logic [5:0]   idx;
    logic [7:0]   way_en;
    logic [1:0]   coh;
    logic [20:0]  tag;
    logic         rr, wr, fr;
    logic         chk;
    logic [15:0]  ecoh;
    logic [167:0] etag;
    logic [7:0]   ehw;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [167:0] act, input logic [167:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Counts busy cycles starting at the current negedge; optionally pulses
  // flush on one chosen cycle of the sweep.
  task automatic count_busy(input string name, input int flush_at, input int exp_n);
    int n = 0;
    while (io_busy && n < 200) begin
      io_flush_valid = (n == flush_at);
      n++;
      @(negedge clock);
    end
    io_flush_valid = 0;
    check(name, n, exp_n);
  endtask

  task automatic apply(input vec_t v, input int i);
    @(negedge clock);
    io_write_valid = v.wv; io_flush_valid = v.fv; io_read_valid = v.rv;
    io_read_bits_idx = v.idx; io_write_bits_idx = v.idx;
    io_read_bits_tag = v.tag; io_write_bits_tag = v.tag;
    io_write_bits_way_en = v.way_en; io_write_bits_coh = v.coh;
    #1;
    check($sformatf("v%0d read_ready", i),  io_read_ready,  v.rr);
    check($sformatf("v%0d write_ready", i), io_write_ready, v.wr);
    check($sformatf("v%0d flush_ready", i), io_flush_ready, v.fr);
    @(posedge clock); #1;
    io_write_valid = 0; io_flush_valid = 0; io_read_valid = 0;
    check($sformatf("v%0d resp_valid", i), io_resp_valid, v.rv && v.rr);
    if (v.chk) begin
      check($sformatf("v%0d resp_coh", i), io_resp_coh, v.ecoh);
      check($sformatf("v%0d resp_tag", i), io_resp_tag, v.etag);
      check($sformatf("v%0d hit_way", i),  io_resp_hit_way, v.ehw);
      check($sformatf("v%0d hit", i),      io_resp_hit, |v.ehw);
    end
  endtask

  initial begin
    logic [167:0] t0, t7;
    vec_t v;
    int n;

    t0 = (168'h1ABCD) | (168'h1ABCD << 42);
    t7 = t0 | (168'h1ABCD << 21) | (168'h1ABCD << 63) | (168'h777 << 147);
    //          wv fv rv idx    way_en  coh tag        rr wr fr chk ecoh      etag                    ehw
    vt[0]  = '{0, 0, 1, 6'd5, 8'h00, 0, 21'h0,     1, 1, 1, 1, 16'h0000, 168'h0,                  8'h00};
    vt[1]  = '{1, 0, 0, 6'd3, 8'h05, 2, 21'h1ABCD, 0, 1, 0, 0, 16'h0000, 168'h0,                  8'h00};
    vt[2]  = '{0, 0, 1, 6'd3, 8'h00, 0, 21'h1ABCD, 1, 1, 1, 1, 16'h0022, t0,                      8'h01};
    vt[3]  = '{0, 0, 1, 6'd3, 8'h00, 0, 21'h1ABCE, 1, 1, 1, 1, 16'h0022, t0,                      8'h00};
    vt[4]  = '{1, 1, 1, 6'd3, 8'h80, 1, 21'h00777, 0, 1, 0, 0, 16'h0000, 168'h0,                  8'h00};
    vt[5]  = '{0, 0, 1, 6'd3, 8'h00, 0, 21'h00777, 1, 1, 1, 1, 16'h4022, t0 | (168'h777 << 147), 8'h80};
    vt[6]  = '{1, 0, 0, 6'd3, 8'h0A, 3, 21'h1ABCD, 0, 1, 0, 0, 16'h0000, 168'h0,                  8'h00};
    vt[7]  = '{0, 0, 1, 6'd3, 8'h00, 0, 21'h1ABCD, 1, 1, 1, 1, 16'h40EE, t7,                      8'h01};
    vt[8]  = '{0, 0, 1, 6'd4, 8'h00, 0, 21'h0,     1, 1, 1, 1, 16'h0000, 168'h0,                  8'h00};
    vt[9]  = '{1, 0, 0, 6'd4, 8'h00, 3, 21'h5,     0, 1, 0, 0, 16'h0000, 168'h0,                  8'h00};
    vt[10] = '{0, 0, 1, 6'd4, 8'h00, 0, 21'h5,     1, 1, 1, 1, 16'h0000, 168'h0,                  8'h00};

    // Reset state while reset is held.
    repeat (2) @(negedge clock);
    check("rst busy", io_busy, 1);
    check("rst read_ready", io_read_ready, 0);
    check("rst write_ready", io_write_ready, 0);
    check("rst flush_ready", io_flush_ready, 0);
    check("rst resp_valid", io_resp_valid, 0);
    check("rst resp_coh", io_resp_coh, 0);
    check("rst resp_tag", io_resp_tag, 0);
    check("rst hit", io_resp_hit, 0);
    check("rst hit_way", io_resp_hit_way, 0);

    reset = 0;
    count_busy("initial sweep length", -1, 64);
    check("post-sweep read_ready", io_read_ready, 1);
    check("post-sweep write_ready", io_write_ready, 1);

    for (int i = 0; i < 11; i++) apply(vt[i], i);

    // Write to the read index the cycle after a read must not alter the response.
    @(negedge clock);
    io_read_valid = 1; io_read_bits_idx = 3; io_read_bits_tag = 21'h1ABCD;
    @(posedge clock); #1;
    io_read_valid = 0;
    io_write_valid = 1; io_write_bits_idx = 3; io_write_bits_way_en = 8'hFF;
    io_write_bits_coh = 1; io_write_bits_tag = 0;
    check("raw resp_valid", io_resp_valid, 1);
    check("raw resp_coh", io_resp_coh, 16'h40EE);
    check("raw hit_way", io_resp_hit_way, 8'h01);
    @(posedge clock); #1;
    io_write_valid = 0;
    check("hold resp_valid low", io_resp_valid, 0);
    check("hold resp_coh", io_resp_coh, 16'h40EE);
    check("hold resp_tag", io_resp_tag, t7);
    check("hold hit", io_resp_hit, 1);
    v = '{0, 0, 1, 6'd3, 8'h00, 0, 21'h0, 1, 1, 1, 1, 16'h5555, 168'h0, 8'h01};
    apply(v, 20);

    // Flush with a second flush pulse during the sweep.
    @(negedge clock);
    io_flush_valid = 1; io_read_valid = 1; io_read_bits_idx = 3;
    #1;
    check("flush flush_ready", io_flush_ready, 1);
    check("flush read_ready", io_read_ready, 0);
    @(posedge clock); #1;
    io_flush_valid = 0; io_read_valid = 0;
    check("flush resp_valid", io_resp_valid, 0);
    @(negedge clock);
    count_busy("flush sweep length", 30, 64);
    v = '{0, 0, 1, 6'd3, 8'h00, 0, 21'h0, 1, 1, 1, 1, 16'h0000, 168'h0, 8'h00};
    apply(v, 21);

    // Reset during a pending response, then reset mid-sweep.
    v = '{1, 0, 0, 6'd7, 8'h01, 1, 21'h55, 0, 1, 0, 0, 16'h0, 168'h0, 8'h00};
    apply(v, 22);
    v = '{0, 0, 1, 6'd7, 8'h00, 0, 21'h55, 1, 1, 1, 1, 16'h0001, 168'h55, 8'h01};
    apply(v, 23);
    @(negedge clock);
    io_read_valid = 1; io_read_bits_idx = 7; io_read_bits_tag = 21'h55;
    reset = 1;
    @(posedge clock); #1;
    io_read_valid = 0;
    check("rst2 resp_valid", io_resp_valid, 0);
    check("rst2 resp_coh", io_resp_coh, 0);
    check("rst2 resp_tag", io_resp_tag, 0);
    check("rst2 hit", io_resp_hit, 0);
    check("rst2 busy", io_busy, 1);
    check("rst2 write_ready", io_write_ready, 0);
    @(negedge clock);
    reset = 0;
    repeat (20) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    count_busy("restarted sweep length", -1, 64);
    v = '{0, 0, 1, 6'd7, 8'h00, 0, 21'h55, 1, 1, 1, 1, 16'h0000, 168'h0, 8'h00};
    apply(v, 24);

    // Small instance.
    @(negedge clock);
    reset2 = 0;
    n = 0;
    while (busy2 && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("p2 sweep length", n, 16);
    wv2 = 1; widx2 = 9; wen2 = 4'b1000; wcoh2 = 3'd5; wtag2 = 12'hABC;
    @(posedge clock); #1;
    wv2 = 0;
    @(negedge clock);
    rv2 = 1; ridx2 = 9; rtag2 = 12'hABC;
    #1;
    check("p2 read_ready", rr2, 1);
    @(posedge clock); #1;
    rv2 = 0;
    check("p2 resp_valid", respv2, 1);
    check("p2 resp_coh", rcoh2, 12'hA00);
    check("p2 resp_tag", rtago2, 48'hABC0_0000_0000);
    check("p2 hit_way", hw2, 4'b1000);
    check("p2 hit", hit2, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
